// File: rtl/ps2_paddle_quad_if.sv
// PS/2 pin and paddle-output bundle for ps2_paddle_quad.
// master: drives the PS/2 lines (keyboard side / bench) and observes the outputs.
// slave : the paddle block itself.
interface ps2_paddle_quad_if;
  logic ps2_clk;
  logic ps2_data;
  logic quadA;
  logic quadB;
  logic key_left;
  logic key_right;
  logic frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  quadA,
    input  quadB,
    input  key_left,
    input  key_right,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output quadA,
    output quadB,
    output key_left,
    output key_right,
    output frame_err
  );
endinterface

// File: rtl/ps2_paddle_quad.sv
// PS/2 keyboard front end for the Pong paddle. It receives scan codes and
// tracks the held state of the Left and Right arrow keys. From that it
// synthesises a quadrature pair, so the game's encoder input can be driven
// from a keyboard.
module ps2_paddle_quad #(
  parameter int STEP_DIV = 50000,
  parameter int TIMEOUT  = 5000
) (
  input logic               clk,
  input logic               reset_n,
  ps2_paddle_quad_if.slave  bus
);

  localparam int RW = $clog2(STEP_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Next Gray phase {A,B}; right walks 00-01-11-10, left walks the reverse.
  function automatic logic [1:0] quad_next(input logic [1:0] ph, input logic right);
    logic [1:0] nx;
    case (ph)
      2'b00:   nx = right ? 2'b01 : 2'b10;
      2'b01:   nx = right ? 2'b11 : 2'b00;
      2'b11:   nx = right ? 2'b10 : 2'b01;
      2'b10:   nx = right ? 2'b00 : 2'b11;
      default: nx = 2'b00;
    endcase
    return nx;
  endfunction

  // Synchronizers and fall-detect history (reset low so release never fakes a fall).
  logic ps2c_meta_q, ps2c_sync_q, ps2c_hist_q;
  logic ps2d_meta_q, ps2d_sync_q;
  logic fall_s;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          key_left_q, key_left_d;
  logic          key_right_q, key_right_d;
  logic          frame_err_q, frame_err_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [1:0]    phase_q, phase_d;
  logic          byte_ok_s;
  logic          sole_s;

  // Two-flop synchronizers for both PS/2 pins plus one history flop on the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2c_meta_q <= 1'b0;
      ps2c_sync_q <= 1'b0;
      ps2c_hist_q <= 1'b0;
      ps2d_meta_q <= 1'b0;
      ps2d_sync_q <= 1'b0;
    end else begin
      ps2c_meta_q <= bus.ps2_clk;
      ps2c_sync_q <= ps2c_meta_q;
      ps2c_hist_q <= ps2c_sync_q;
      ps2d_meta_q <= bus.ps2_data;
      ps2d_sync_q <= ps2d_meta_q;
    end
  end

  assign fall_s = ps2c_hist_q & ~ps2c_sync_q;

  // Receiver FSM, timeout, and scan-code decoder next-state logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_left_d  = key_left_q;
    key_right_d = key_right_q;
    frame_err_d = 1'b0;
    byte_ok_s   = 1'b0;

    if (fall_s) begin
      // A fall always beats a same-cycle timeout.
      tmo_d = {TW{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (!ps2d_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2d_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_d   = ps2d_sync_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2d_sync_q && odd_parity_ok(shift_q, par_q)) begin
            byte_ok_s = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      state_d     = ST_IDLE;
      tmo_d       = {TW{1'b0}};
      frame_err_d = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (byte_ok_s) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q && (shift_q == 8'h6B)) begin
          key_left_d = ~brk_q;
        end else begin
          key_left_d = key_left_q;
        end
        if (ext_q && (shift_q == 8'h74)) begin
          key_right_d = ~brk_q;
        end else begin
          key_right_d = key_right_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else begin
      ext_d = ext_q;
      brk_d = brk_q;
    end
  end

  // Step-rate counter and phase advance; direction comes from the registered keys.
  always_comb begin
    rate_d  = rate_q;
    phase_d = phase_q;
    sole_s  = key_left_q ^ key_right_q;
    if (sole_s) begin
      if (rate_q == RW'(STEP_DIV - 1)) begin
        rate_d  = {RW{1'b0}};
        phase_d = quad_next(phase_q, key_right_q);
      end else begin
        rate_d  = rate_q + RW'(1);
        phase_d = phase_q;
      end
    end else begin
      rate_d  = {RW{1'b0}};
      phase_d = phase_q;
    end
  end

  // State registers for receiver, decoder, keys and quadrature generator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= {TW{1'b0}};
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_left_q  <= 1'b0;
      key_right_q <= 1'b0;
      frame_err_q <= 1'b0;
      rate_q      <= {RW{1'b0}};
      phase_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_left_q  <= key_left_d;
      key_right_q <= key_right_d;
      frame_err_q <= frame_err_d;
      rate_q      <= rate_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.quadA     = phase_q[1];
  assign bus.quadB     = phase_q[0];
  assign bus.key_left  = key_left_q;
  assign bus.key_right = key_right_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_paddle_quad.sv
// Scoreboard bench for ps2_paddle_quad: every predicted output change
// (value and cycle) is queued when the PS/2 stimulus is driven and is
// compared when the output vector actually changes.
module tb_ps2_paddle_quad;

  localparam int STEP_DIV = 4;
  localparam int TIMEOUT  = 40;
  localparam int H        = 4;   // PS/2 half bit period in clk cycles

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  ps2_paddle_quad_if bus();

  ps2_paddle_quad #(.STEP_DIV(STEP_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle stamp: value equals the number of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- expected-event model ----------------
  typedef struct { logic [4:0] v; int c; } ev_t;
  ev_t        exq[$];
  logic       m_kl, m_kr, m_fe;
  logic [1:0] m_ph;
  int         m_next;
  logic [4:0] m_last;
  logic       b_ext, b_brk;
  logic [1:0] right_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic [1:0] ph_step(input logic [1:0] p, input logic right);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (right_seq[i] == p) idx = i;
    return right ? right_seq[(idx + 1) % 4] : right_seq[(idx + 3) % 4];
  endfunction

  function automatic logic [4:0] mvec();
    return {m_fe, m_kl, m_kr, m_ph};
  endfunction

  task automatic push_if_changed(input int c);
    ev_t e;
    if (mvec() != m_last) begin
      e.v = mvec();
      e.c = c;
      exq.push_back(e);
      m_last = mvec();
    end
  endtask

  // Queue the quadrature steps due strictly before cycle t.
  task automatic emit_upto(input int t);
    while ((m_kl ^ m_kr) && (m_next < t)) begin
      m_ph = ph_step(m_ph, m_kr);
      push_if_changed(m_next);
      m_next += STEP_DIV;
    end
  endtask

  // Outputs take new key / error values on the edge of cycle t.
  task automatic model_event(input int t, input logic kl, input logic kr, input logic fe);
    logic was_sole;
    emit_upto(t);
    was_sole = m_kl ^ m_kr;
    if (was_sole && (m_next == t)) begin
      m_ph   = ph_step(m_ph, m_kr);
      m_next += STEP_DIV;
    end
    m_kl = kl;
    m_kr = kr;
    m_fe = fe;
    if ((kl ^ kr) && !was_sole) m_next = t + STEP_DIV;
    push_if_changed(t);
  endtask

  task automatic predict_err(input int t);
    model_event(t, m_kl, m_kr, 1'b1);
    model_event(t + 1, m_kl, m_kr, 1'b0);
    b_ext = 1'b0;
    b_brk = 1'b0;
  endtask

  task automatic predict_byte(input logic [7:0] b, input logic bad, input int t);
    logic nkl, nkr;
    if (bad) begin
      predict_err(t);
    end else if (b == 8'hE0) begin
      b_ext = 1'b1;
    end else if (b == 8'hF0) begin
      b_brk = 1'b1;
    end else begin
      nkl = m_kl;
      nkr = m_kr;
      if (b_ext && (b == 8'h6B)) nkl = ~b_brk;
      if (b_ext && (b == 8'h74)) nkr = ~b_brk;
      model_event(t, nkl, nkr, 1'b0);
      b_ext = 1'b0;
      b_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    exq.delete();
    m_kl = 1'b0; m_kr = 1'b0; m_fe = 1'b0; m_ph = 2'b00;
    m_next = 0; m_last = 5'd0; b_ext = 1'b0; b_brk = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  logic       mon_en   = 1'b0;
  logic [4:0] prev_vec = 5'd0;
  logic [4:0] cur_vec;
  ev_t        mon_e;

  always @(negedge clk) begin
    cur_vec = {bus.frame_err, bus.key_left, bus.key_right, bus.quadA, bus.quadB};
    if (mon_en) begin
      emit_upto(cyc + 1);
      if (cur_vec !== prev_vec) begin
        if (exq.size() == 0) begin
          chk("unexpected_change", {27'd0, cur_vec}, {27'd0, prev_vec});
        end else begin
          mon_e = exq.pop_front();
          chk("out_vec", {27'd0, cur_vec}, {27'd0, mon_e.v});
          chk("out_cyc", cyc, mon_e.c);
        end
      end else if ((exq.size() != 0) && (exq[0].c <= cyc)) begin
        mon_e = exq.pop_front();
        chk("missed_change", {27'd0, cur_vec}, {27'd0, mon_e.v});
      end
    end
    prev_vec = cur_vec;
  end

  // ---------------- PS/2 stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.ps2_data = fr[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) predict_byte(b, bad, cyc + 3);
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
    bus.ps2_data = 1'b1;
  endtask

  // Start bit plus n-1 data bits, then the line goes quiet.
  task automatic send_partial(input int n, input logic expect_timeout);
    logic [10:0] fr;
    int          last;
    fr   = {1'b1, 1'b0, 8'h5A, 1'b0};
    last = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ps2_data = fr[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      last = cyc;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    if (expect_timeout) predict_err(last + 3 + TIMEOUT);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {27'd0, bus.frame_err, bus.key_left, bus.key_right, bus.quadA, bus.quadB}, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();

    // Reset held while ps2_clk toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.ps2_clk = ~bus.ps2_clk;
      #1 chk_outputs_zero("reset_outputs");
    end
    @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (20) @(negedge clk);
    #1 chk_outputs_zero("post_reset_idle");

    // Right make, a few steps, then right break.
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    #1 chk("right_make", {31'd0, bus.key_right}, 32'd1);
    repeat (12) @(negedge clk);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    repeat (100) @(negedge clk);
    #1 chk("right_break", {31'd0, bus.key_right}, 32'd0);
    chk("phase_frozen", {30'd0, bus.quadA, bus.quadB}, {30'd0, m_ph});

    // Left alone, then right too: both held freezes the phase.
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    repeat (16) @(negedge clk);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    repeat (100) @(negedge clk);
    #1 chk("both_held", {30'd0, bus.key_left, bus.key_right}, 32'd3);
    // Release left (right alone steps), then release right.
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    repeat (10) @(negedge clk);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    repeat (20) @(negedge clk);
    #1 chk("all_released", {30'd0, bus.key_left, bus.key_right}, 32'd0);

    // Parity error after E0; a following plain 6B must not set key_left.
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b1);
    send_byte(8'h6B, 1'b0);
    #1 chk("ext_cleared", {31'd0, bus.key_left}, 32'd0);
    // Timeout after four bits.
    send_partial(4, 1'b1);
    repeat (TIMEOUT + 10) @(negedge clk);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    #1 chk("left_after_errors", {31'd0, bus.key_left}, 32'd1);
    repeat (30) @(negedge clk);

    // Reset in the middle of a frame.
    send_partial(5, 1'b0);
    @(negedge clk);
    #1 chk("queue_drained_pre_reset", exq.size(), 32'd0);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1 chk_outputs_zero("mid_frame_reset");
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    repeat (40) @(negedge clk);
    #1 chk("right_after_reset", {30'd0, bus.key_left, bus.key_right}, 32'd1);
    chk("phase_after_reset", {30'd0, bus.quadA, bus.quadB}, {30'd0, m_ph});
    chk("queue_drained_end", exq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
